// File: rtl/opll_pwm_dac_if.sv
// Sample/control bundle between the OPLL mix output and the single-pin audio DAC.
// The master drives samples and controls; the slave (the DAC) drives the pin, level and drop flag.
interface opll_pwm_dac_if;
  logic               i_sample_strb;
  logic signed [15:0] i_sample;
  logic               i_mode;
  logic               i_mute;
  logic               o_pwm;
  logic        [7:0]  o_level;
  logic               o_drop;

  modport master (
    output i_sample_strb, i_sample, i_mode, i_mute,
    input  o_pwm, o_level, o_drop
  );

  modport slave (
    input  i_sample_strb, i_sample, i_mode, i_mute,
    output o_pwm, o_level, o_drop
  );
endinterface

// File: rtl/opll_pwm_dac.sv
// One-pin audio DAC for the OPLL mix: offset-binary conversion, a one-deep pending
// sample slot, and either fixed-period PWM or first-order delta-sigma on o_pwm.
module opll_pwm_dac #(
  parameter int PWM_BITS = 8
) (
  input logic            clk,
  input logic            rst_n,
  opll_pwm_dac_if.slave  bus
);

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] MIDPOINT = 16'h8000;

  function automatic logic [DATA_W-1:0] to_offset(input logic signed [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

  // capture stage
  logic [DATA_W-1:0]   pend_p0;
  logic                pend_v_p0;
  logic                drop_p0;

  // active stage
  logic [DATA_W-1:0]   cur_p1;
  logic [DATA_W-1:0]   acc_p1;
  logic [PWM_BITS-1:0] cnt_p1;
  logic                mode_p1;
  logic                pwm_p1;

  logic                mode_switch;
  logic                load_point;
  logic                load_en;
  logic                take_pend;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   capture_val;
  logic [PWM_BITS-1:0] duty;
  logic [DATA_W:0]     ds_sum;

  always_comb begin
    mode_switch = (bus.i_mode != mode_p1);
    // PWM only reloads at the period boundary so a period is never split between two duties
    load_point  = mode_p1 ? 1'b1 : (cnt_p1 == '1);
    // mute forces a midpoint load even with nothing pending
    load_en     = !mode_switch && load_point && (pend_v_p0 || bus.i_mute);
    take_pend   = load_en && pend_v_p0;
    load_val    = bus.i_mute ? MIDPOINT : pend_p0;
    capture_val = bus.i_mute ? MIDPOINT : to_offset(bus.i_sample);
    duty        = cur_p1[DATA_W-1 -: PWM_BITS];
    ds_sum      = {1'b0, acc_p1} + {1'b0, cur_p1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p0   <= MIDPOINT;
      pend_v_p0 <= 1'b0;
      drop_p0   <= 1'b0;
    end else begin
      // a new strobe wins over a same-cycle consume, keeping the slot occupied
      if (bus.i_sample_strb) begin
        pend_p0   <= capture_val;
        pend_v_p0 <= 1'b1;
      end else if (take_pend) begin
        pend_v_p0 <= 1'b0;
      end
      drop_p0 <= bus.i_sample_strb && pend_v_p0 && !take_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_p1  <= MIDPOINT;
      acc_p1  <= '0;
      cnt_p1  <= '0;
      mode_p1 <= 1'b0;
      pwm_p1  <= 1'b0;
    end else begin
      if (mode_switch) begin
        mode_p1 <= bus.i_mode;
        cnt_p1  <= '0;
        acc_p1  <= '0;
        pwm_p1  <= 1'b0;
      end else if (mode_p1) begin
        acc_p1  <= ds_sum[DATA_W-1:0];
        pwm_p1  <= ds_sum[DATA_W];
      end else begin
        cnt_p1  <= cnt_p1 + 1'b1;
        pwm_p1  <= (cnt_p1 < duty);
      end
      if (load_en) begin
        cur_p1 <= load_val;
      end
    end
  end

  assign bus.o_pwm   = pwm_p1;
  assign bus.o_level = cur_p1[DATA_W-1 -: 8];
  assign bus.o_drop  = drop_p0;

endmodule

// File: tb/tb_opll_pwm_dac.sv
// Directed bench for opll_pwm_dac with PWM_BITS = 8 (256-clock PWM period).
module tb_opll_pwm_dac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  opll_pwm_dac_if bus ();

  opll_pwm_dac #(.PWM_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // edges since reset release; equals the PWM counter value sampled at the next edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic strobe(input logic signed [15:0] v);
    bus.i_sample_strb = 1'b1;
    bus.i_sample      = v;
    @(negedge clk);
    bus.i_sample_strb = 1'b0;
    bus.i_sample      = '0;
  endtask

  task automatic settle();
    repeat (261) @(negedge clk);
  endtask

  task automatic count_period(output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus.o_pwm === 1'b1) highs++;
    end
  endtask

  task automatic align_to(input int phase, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ((cyc % 256) == phase) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int highs;
    int bad;
    rst_n = 1'b0;
    bus.i_sample_strb = 1'b0;
    bus.i_sample = '0;
    bus.i_mode = 1'b0;
    bus.i_mute = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", bus.o_pwm); end
    n_checks++;
    if (bus.o_level !== 8'h80) begin n_fail++; $display("FAIL reset_level: got %h want 80", bus.o_level); end
    n_checks++;
    if (bus.o_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", bus.o_drop); end
    rst_n = 1'b1;
    highs = 0;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (bus.o_pwm === 1'b1) highs++;
      if (bus.o_pwm !== ((i <= 128) ? 1'b1 : 1'b0)) bad++;
    end
    n_checks++;
    if (highs !== 128) begin n_fail++; $display("FAIL reset_period_highs: got %0d want 128", highs); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_period_shape: got %0d misplaced bits want 0", bad); end
  endtask

  task automatic test_pwm_extremes();
    int highs;
    strobe(-16'sd32768);
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 0) begin n_fail++; $display("FAIL pwm_min_highs: got %0d want 0", highs); end
    n_checks++;
    if (bus.o_level !== 8'h00) begin n_fail++; $display("FAIL pwm_min_level: got %h want 00", bus.o_level); end
    strobe(16'sd32767);
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 255) begin n_fail++; $display("FAIL pwm_max_highs: got %0d want 255", highs); end
    n_checks++;
    if (bus.o_level !== 8'hFF) begin n_fail++; $display("FAIL pwm_max_level: got %h want FF", bus.o_level); end
  endtask

  task automatic test_drop();
    int highs;
    bit ok;
    align_to(10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop_align: got timeout want phase 10"); end
    strobe(16'sh1000);
    n_checks++;
    if (bus.o_drop !== 1'b0) begin n_fail++; $display("FAIL drop_first: got %b want 0", bus.o_drop); end
    repeat (4) @(negedge clk);
    strobe(16'sh2000);
    n_checks++;
    if (bus.o_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", bus.o_drop); end
    @(negedge clk);
    n_checks++;
    if (bus.o_drop !== 1'b0) begin n_fail++; $display("FAIL drop_width: got %b want 0", bus.o_drop); end
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 160) begin n_fail++; $display("FAIL drop_highs: got %0d want 160", highs); end
    n_checks++;
    if (bus.o_level !== 8'hA0) begin n_fail++; $display("FAIL drop_level: got %h want A0", bus.o_level); end
  endtask

  task automatic test_mute();
    int highs;
    strobe(16'sh7F00);
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 255) begin n_fail++; $display("FAIL mute_pre_highs: got %0d want 255", highs); end
    bus.i_mute = 1'b1;
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 128) begin n_fail++; $display("FAIL mute_highs: got %0d want 128", highs); end
    n_checks++;
    if (bus.o_level !== 8'h80) begin n_fail++; $display("FAIL mute_level: got %h want 80", bus.o_level); end
    strobe(16'sh7000);
    bus.i_mute = 1'b0;
    settle();
    count_period(highs);
    n_checks++;
    if (highs !== 128) begin n_fail++; $display("FAIL mute_capture_highs: got %0d want 128", highs); end
  endtask

  task automatic test_mode_switch();
    bit ok;
    logic [3:0] got;
    align_to(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL switch_align: got timeout want phase 20"); end
    n_checks++;
    if (bus.o_pwm !== 1'b1) begin n_fail++; $display("FAIL switch_pre_pwm: got %b want 1", bus.o_pwm); end
    bus.i_mode = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_pwm !== 1'b0) begin n_fail++; $display("FAIL switch_pwm_low: got %b want 0", bus.o_pwm); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got[i] = bus.o_pwm;
    end
    n_checks++;
    if (got !== 4'b1010) begin n_fail++; $display("FAIL switch_acc_restart: got %b want 1010", got); end
  endtask

  task automatic test_delta_sigma();
    logic [7:0] b;
    int ones_a;
    int ones_b;
    int alt_bad;
    strobe(16'sh4000);
    n_checks++;
    if (bus.o_level !== 8'h80) begin n_fail++; $display("FAIL ds_level_e0: got %h want 80", bus.o_level); end
    @(negedge clk);
    n_checks++;
    if (bus.o_level !== 8'hC0) begin n_fail++; $display("FAIL ds_level_e1: got %h want C0", bus.o_level); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b[i] = bus.o_pwm;
    end
    ones_a = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    ones_b = int'(b[4]) + int'(b[5]) + int'(b[6]) + int'(b[7]);
    n_checks++;
    if (ones_a !== 3 || ones_b !== 3) begin
      n_fail++; $display("FAIL ds_3of4_density: got %0d,%0d want 3,3", ones_a, ones_b);
    end
    n_checks++;
    if (b[3:0] !== b[7:4]) begin n_fail++; $display("FAIL ds_3of4_period: got %b want period 4", b); end
    strobe(16'sh0000);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b[i] = bus.o_pwm;
    end
    alt_bad = 0;
    for (int i = 0; i < 7; i++) if (b[i] === b[i+1]) alt_bad++;
    n_checks++;
    if (alt_bad !== 0) begin n_fail++; $display("FAIL ds_alternate: got %b want alternating", b); end
    n_checks++;
    if (bus.o_level !== 8'h80) begin n_fail++; $display("FAIL ds_mid_level: got %h want 80", bus.o_level); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int highs;
    int bad;
    strobe(16'sh7FFF);
    repeat (3) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.o_pwm === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rstmid_find_high: got timeout want o_pwm 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_pwm !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_pwm: got %b want 0", bus.o_pwm); end
    n_checks++;
    if (bus.o_level !== 8'h80) begin n_fail++; $display("FAIL rstmid_async_level: got %h want 80", bus.o_level); end
    bus.i_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (bus.o_pwm === 1'b1) highs++;
      if (bus.o_pwm !== ((i <= 128) ? 1'b1 : 1'b0)) bad++;
    end
    n_checks++;
    if (highs !== 128 || bad !== 0) begin
      n_fail++; $display("FAIL rstmid_after_release: got %0d highs %0d misplaced want 128 highs 0 misplaced", highs, bad);
    end
    n_checks++;
    if (bus.o_drop !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got %b want 0", bus.o_drop); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_pwm_extremes();
    test_drop();
    test_mute();
    test_mode_switch();
    test_delta_sigma();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
